// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg -- shared types and constants for the data memory controller.
//   DMEM_MAX_WAIT : default cycle budget for m_gnt / m_rvalid before abandoning
//   WAIT_CNT_W    : width of the wait counter
//   dmem_state_e  : controller FSM states
//   word_align()  : clears the byte-offset bits of a byte address
// ---------------------------------------------------------------------------
package dmem_pkg;

    localparam int DMEM_MAX_WAIT = 255;
    localparam int WAIT_CNT_W    = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } dmem_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl_if -- request/grant/read-valid memory bus.
//   master : controller side (drives m_req, m_we, m_addr, m_wdata)
//   slave  : memory side     (drives m_gnt, m_rvalid, m_rdata)
// ---------------------------------------------------------------------------
interface data_mem_ctrl_if;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_gnt;
    logic        m_rvalid;
    logic [31:0] m_rdata;

    modport master (
        output m_req, m_we, m_addr, m_wdata,
        input  m_gnt, m_rvalid, m_rdata
    );

    modport slave (
        input  m_req, m_we, m_addr, m_wdata,
        output m_gnt, m_rvalid, m_rdata
    );
endinterface

// File: rtl/dmem_wbuf.sv
// ---------------------------------------------------------------------------
// dmem_wbuf -- one-entry posted write buffer (valid, word address, data).
//   clk, reset (sync, active-low)
//   push, push_addr, push_data : capture a store (sets valid)
//   pop                        : entry has been issued or abandoned (clears valid)
//   valid, addr, data          : current entry
// ---------------------------------------------------------------------------
module dmem_wbuf (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic [31:0] push_addr,
    input  logic [31:0] push_data,
    input  logic        pop,
    output logic        valid,
    output logic [31:0] addr,
    output logic [31:0] data
);
    logic        valid_q, valid_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (pop) begin
            valid_d = 1'b0;
        end
        if (push) begin
            valid_d = 1'b1;
            addr_d  = push_addr;
            data_d  = push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign addr  = addr_q;
    assign data  = data_q;
endmodule

// File: rtl/data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl -- datapath-to-memory load/store controller.
//   clk, reset (sync, active-low)
//   addr, wdata, mem_read, mem_write : access request from the datapath
//   rdata   : load result (held until the next load completes)
//   stall   : freeze PC / suppress register write while the access is in flight
//   bus_err : sticky timeout / misalignment flag, cleared only by reset
//   mem     : memory bus (data_mem_ctrl_if.master)
// Parameter MAX_WAIT: cycles allowed in REQ or WAIT before abandoning.
// Optional macro DMEM_WBUF_EN adds a one-entry posted write buffer so that
// stores complete without stalling when the controller is idle.
// ---------------------------------------------------------------------------
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int MAX_WAIT = DMEM_MAX_WAIT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            addr,
    input  logic [31:0]            wdata,
    input  logic                   mem_read,
    input  logic                   mem_write,
    output logic [31:0]            rdata,
    output logic                   stall,
    output logic                   bus_err,
    data_mem_ctrl_if.master        mem
);
    // Last counter value before the budget is exhausted: m_req / WAIT last
    // exactly MAX_WAIT cycles.
    localparam logic [WAIT_CNT_W-1:0] TO_LAST = WAIT_CNT_W'(MAX_WAIT - 1);

    dmem_state_e           state_q, state_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]           addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  bus_err_q, bus_err_d;

    logic        is_acc;
    logic        timeout;
    logic        buf_valid;
    logic [31:0] buf_addr;
    logic [31:0] buf_data;

    assign is_acc  = mem_read | mem_write;
    assign timeout = (cnt_q == TO_LAST);

`ifdef DMEM_WBUF_EN
    localparam bit WBUF_EN = 1'b1;
    logic buf_push;
    logic buf_pop;

    // Stores are posted only from IDLE into an empty buffer; the entry leaves
    // when the drain is granted or abandoned on timeout.
    assign buf_push = (state_q == S_IDLE) && mem_write && !buf_valid;
    assign buf_pop  = (state_q == S_REQ) && buf_valid && (mem.m_gnt || timeout);

    dmem_wbuf u_wbuf (
        .clk       (clk),
        .reset     (reset),
        .push      (buf_push),
        .push_addr (word_align(addr)),
        .push_data (wdata),
        .pop       (buf_pop),
        .valid     (buf_valid),
        .addr      (buf_addr),
        .data      (buf_data)
    );
`else
    localparam bit WBUF_EN = 1'b0;
    assign buf_valid = 1'b0;
    assign buf_addr  = '0;
    assign buf_data  = '0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            rdata_q   <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            rdata_q   <= rdata_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        rdata_d   = rdata_q;
        bus_err_d = bus_err_q;
        unique case (state_q)
            S_IDLE: begin
                if (is_acc) begin
                    state_d = S_REQ;
                    addr_d  = word_align(addr);
                    wdata_d = wdata;
                    // Read+write together is treated as a write.
                    we_d    = mem_write;
                    if (addr[1:0] != 2'b00) begin
                        bus_err_d = 1'b1;
                    end
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + WAIT_CNT_W'(1);
                if (mem.m_gnt) begin
                    cnt_d = '0;
                    if (buf_valid) begin
                        state_d = S_IDLE;   // posted store: nobody waits on it
                    end else if (we_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else if (timeout) begin
                    cnt_d     = '0;
                    bus_err_d = 1'b1;
                    if (buf_valid) begin
                        // DONE would release a load stalled behind the drain.
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DONE;
                        rdata_d = '0;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + WAIT_CNT_W'(1);
                if (mem.m_rvalid) begin
                    cnt_d   = '0;
                    rdata_d = mem.m_rdata;
                    state_d = S_DONE;
                end else if (timeout) begin
                    cnt_d     = '0;
                    bus_err_d = 1'b1;
                    rdata_d   = '0;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                // The datapath still shows the finished access this cycle.
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        mem.m_req   = (state_q == S_REQ);
        mem.m_we    = buf_valid ? 1'b1 : we_q;
        mem.m_addr  = buf_valid ? buf_addr : addr_q;
        mem.m_wdata = buf_valid ? buf_data : wdata_q;
        stall       = 1'b0;
        unique case (state_q)
            S_IDLE:  stall = is_acc & ~(WBUF_EN & mem_write & ~buf_valid);
            S_REQ:   stall = buf_valid ? is_acc : 1'b1;
            S_WAIT:  stall = 1'b1;
            S_DONE:  stall = 1'b0;
            default: stall = 1'b0;
        endcase
        stall = stall & reset;
    end

    assign rdata   = rdata_q;
    assign bus_err = bus_err_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;
    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] rdata;
    logic        stall;
    logic        bus_err;

    int n_checks = 0;
    int n_fails  = 0;

    data_mem_ctrl_if bus ();

    data_mem_ctrl #(.MAX_WAIT(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .wdata     (wdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .rdata     (rdata),
        .stall     (stall),
        .bus_err   (bus_err),
        .mem       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset         = 1'b0;
        addr          = '0;
        wdata         = '0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        bus.m_gnt     = 1'b0;
        bus.m_rvalid  = 1'b0;
        bus.m_rdata   = '0;

        // ---- reset state ----
        cyc(); cyc();
        #1;
        chk("rst_m_req",   32'(bus.m_req), 32'd0);
        chk("rst_m_we",    32'(bus.m_we),  32'd0);
        chk("rst_stall",   32'(stall),     32'd0);
        chk("rst_bus_err", 32'(bus_err),   32'd0);
        chk("rst_rdata",   rdata,          32'd0);
        chk("rst_m_addr",  bus.m_addr,     32'd0);
        chk("rst_m_wdata", bus.m_wdata,    32'd0);
        reset = 1'b1;
        cyc();

        // ---- load 0x100: grant first REQ cycle, rvalid next ----
        addr = 32'h100; mem_read = 1'b1; #1;
        chk("ld_idle_stall", 32'(stall),     32'd1);
        chk("ld_idle_m_req", 32'(bus.m_req), 32'd0);
        cyc();
        bus.m_gnt = 1'b1; #1;
        chk("ld_req_m_req",  32'(bus.m_req), 32'd1);
        chk("ld_req_m_we",   32'(bus.m_we),  32'd0);
        chk("ld_req_m_addr", bus.m_addr,     32'h100);
        chk("ld_req_stall",  32'(stall),     32'd1);
        cyc();
        bus.m_gnt = 1'b0; bus.m_rvalid = 1'b1; bus.m_rdata = 32'hDEADBEEF; #1;
        chk("ld_wait_m_req", 32'(bus.m_req), 32'd0);
        chk("ld_wait_stall", 32'(stall),     32'd1);
        cyc();
        bus.m_rvalid = 1'b0; bus.m_rdata = '0; #1;
        chk("ld_done_stall", 32'(stall),     32'd0);
        chk("ld_done_rdata", rdata,          32'hDEADBEEF);
        chk("ld_done_m_req", 32'(bus.m_req), 32'd0);
        cyc();
        mem_read = 1'b0; #1;
        chk("ld_after_m_req", 32'(bus.m_req), 32'd0);
        chk("ld_after_rdata", rdata,          32'hDEADBEEF);
        $display("txn load  addr=%h rdata=%h", 32'h100, rdata);

`ifndef DMEM_WBUF_EN
        // ---- store 0x20, grant delayed 4 cycles ----
        addr = 32'h20; wdata = 32'h12345678; mem_write = 1'b1; #1;
        chk("st_idle_stall", 32'(stall), 32'd1);
        cyc();
        addr = 32'hFFFF_FFF0; wdata = 32'h0BAD_0BAD; // request must already be latched
        for (int k = 0; k < 5; k++) begin
            bus.m_gnt = (k == 4); #1;
            chk("st_req_m_req",   32'(bus.m_req), 32'd1);
            chk("st_req_m_we",    32'(bus.m_we),  32'd1);
            chk("st_req_m_addr",  bus.m_addr,     32'h20);
            chk("st_req_m_wdata", bus.m_wdata,    32'h12345678);
            chk("st_req_stall",   32'(stall),     32'd1);
            cyc();
        end
        bus.m_gnt = 1'b0; #1;
        chk("st_done_stall", 32'(stall),     32'd0);
        chk("st_done_m_req", 32'(bus.m_req), 32'd0);
        chk("st_bus_err",    32'(bus_err),   32'd0);
        cyc();
        mem_write = 1'b0;
        $display("txn store addr=%h wdata=%h", 32'h20, 32'h12345678);
`endif

        // ---- load with no grant: timeout after 8 cycles ----
        addr = 32'h200; mem_read = 1'b1; #1;
        chk("to_idle_stall", 32'(stall), 32'd1);
        cyc();
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("to_req_m_req", 32'(bus.m_req), 32'd1);
            chk("to_req_stall", 32'(stall),     32'd1);
            cyc();
        end
        #1;
        chk("to_done_m_req",   32'(bus.m_req), 32'd0);
        chk("to_done_bus_err", 32'(bus_err),   32'd1);
        chk("to_done_rdata",   rdata,          32'd0);
        chk("to_done_stall",   32'(stall),     32'd0);
        cyc();
        mem_read = 1'b0; #1;
        chk("to_idle_m_req", 32'(bus.m_req), 32'd0);
        $display("txn load  addr=%h timeout bus_err=%0d", 32'h200, bus_err);

        // ---- reset clears bus_err ----
        reset = 1'b0;
        cyc();
        #1;
        chk("rst2_bus_err", 32'(bus_err), 32'd0);
        reset = 1'b1;
        cyc();

        // ---- misaligned load 0x103 ----
        addr = 32'h103; mem_read = 1'b1; #1;
        chk("mis_idle_bus_err", 32'(bus_err), 32'd0);
        cyc();
        bus.m_gnt = 1'b1; #1;
        chk("mis_req_m_addr",  bus.m_addr,    32'h100);
        chk("mis_req_bus_err", 32'(bus_err),  32'd1);
        cyc();
        bus.m_gnt = 1'b0; bus.m_rvalid = 1'b1; bus.m_rdata = 32'hA5A5A5A5;
        cyc();
        bus.m_rvalid = 1'b0; #1;
        chk("mis_done_rdata", rdata, 32'hA5A5A5A5);
        cyc();
        mem_read = 1'b0;
        cyc(); cyc();
        #1;
        chk("mis_sticky_bus_err", 32'(bus_err), 32'd1);
        $display("txn load  addr=%h rdata=%h bus_err=%0d", 32'h103, rdata, bus_err);

        // ---- reset while in WAIT, late rvalid ignored ----
        addr = 32'h40; mem_read = 1'b1;
        cyc();
        bus.m_gnt = 1'b1;
        cyc();
        bus.m_gnt = 1'b0; #1;
        chk("rw_wait_stall", 32'(stall),     32'd1);
        chk("rw_wait_m_req", 32'(bus.m_req), 32'd0);
        reset = 1'b0; mem_read = 1'b0;
        cyc();
        #1;
        chk("rw_m_req",   32'(bus.m_req), 32'd0);
        chk("rw_stall",   32'(stall),     32'd0);
        chk("rw_bus_err", 32'(bus_err),   32'd0);
        chk("rw_rdata",   rdata,          32'd0);
        reset = 1'b1; bus.m_rvalid = 1'b1; bus.m_rdata = 32'h55555555;
        cyc();
        bus.m_rvalid = 1'b0; #1;
        chk("rw_late_rdata", rdata,          32'd0);
        chk("rw_late_m_req", 32'(bus.m_req), 32'd0);
        chk("rw_late_stall", 32'(stall),     32'd0);
        $display("txn reset-in-wait rdata=%h", rdata);

`ifdef DMEM_WBUF_EN
        // ---- posted store then back-to-back load ----
        addr = 32'h30; wdata = 32'hCAFEF00D; mem_write = 1'b1; #1;
        chk("wb_st_stall", 32'(stall), 32'd0);
        cyc();
        addr = 32'h34; mem_write = 1'b0; mem_read = 1'b1; #1;
        chk("wb_drain_stall",   32'(stall),     32'd1);
        chk("wb_drain_m_req",   32'(bus.m_req), 32'd1);
        chk("wb_drain_m_we",    32'(bus.m_we),  32'd1);
        chk("wb_drain_m_addr",  bus.m_addr,     32'h30);
        chk("wb_drain_m_wdata", bus.m_wdata,    32'hCAFEF00D);
        cyc();
        bus.m_gnt = 1'b1; #1;
        chk("wb_drain2_m_addr", bus.m_addr, 32'h30);
        chk("wb_drain2_stall",  32'(stall), 32'd1);
        cyc();
        bus.m_gnt = 1'b0; #1;
        chk("wb_ld_idle_stall", 32'(stall),     32'd1);
        chk("wb_ld_idle_m_req", 32'(bus.m_req), 32'd0);
        cyc();
        bus.m_gnt = 1'b1; #1;
        chk("wb_ld_req_m_we",   32'(bus.m_we), 32'd0);
        chk("wb_ld_req_m_addr", bus.m_addr,    32'h34);
        cyc();
        bus.m_gnt = 1'b0; bus.m_rvalid = 1'b1; bus.m_rdata = 32'h13579BDF;
        cyc();
        bus.m_rvalid = 1'b0; #1;
        chk("wb_ld_done_stall", 32'(stall), 32'd0);
        chk("wb_ld_done_rdata", rdata,      32'h13579BDF);
        cyc();
        mem_read = 1'b0;
        $display("txn posted store addr=%h then load addr=%h rdata=%h", 32'h30, 32'h34, rdata);
`endif

        cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter MAX_WAIT, default 255: cycles allowed for m_gnt or m_rvalid before the access is abandoned.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-low; asserted when 0.
REQ-004 addr  input  32  byte address from the datapath ALU result.
REQ-005 wdata  input  32  store data from the register file second read port.
REQ-006 mem_read  input  1  current instruction is a load.
REQ-007 mem_write  input  1  current instruction is a store.
REQ-008 rdata  output  32  load data to the datapath result mux.
REQ-009 stall  output  1  freezes PC and suppresses register write in the datapath.
REQ-010 bus_err  output  1  sticky flag for a timeout or misaligned access.
REQ-011 m_req  output  1  memory request valid.
REQ-012 m_we  output  1  request is a write.
REQ-013 m_addr  output  32  word-aligned request address.
REQ-014 m_wdata  output  32  write data.
REQ-015 m_gnt  input  1  memory accepted the request this cycle.
REQ-016 m_rvalid  input  1  m_rdata is valid this cycle.
REQ-017 m_rdata  input  32  read data.

Function
REQ-018 The FSM SHALL have four states: IDLE, REQ, WAIT and DONE.
REQ-019 IDLE with mem_read or mem_write SHALL assert stall combinationally in the same cycle and latch addr, wdata and the operation into request registers, then go to REQ.
REQ-020 When mem_read and mem_write are both 1, the block SHALL treat the access as a write.
REQ-021 In REQ, m_req SHALL be 1 with m_addr = {addr[31:2],2'b00}; m_gnt SHALL move a read to WAIT and a write to DONE.
REQ-022 In WAIT, m_rvalid SHALL capture m_rdata into the rdata register and move the FSM to DONE.
REQ-023 In DONE, stall SHALL be 0 and rdata held, so the register file writes; the FSM SHALL return to IDLE without re-issuing the still-asserted request.
REQ-024 Minimum load latency SHALL be 3 stall cycles when m_gnt and m_rvalid each arrive in their first possible cycle.
REQ-025 m_req, m_we, m_addr and m_wdata SHALL stay stable from assertion until m_gnt.
REQ-026 An 8-bit wait counter SHALL clear on entry to REQ or WAIT and increment each cycle there.
REQ-027 When the wait counter reaches MAX_WAIT, the block SHALL drop m_req, set bus_err, set rdata to 0 and go to DONE.
REQ-028 An access with addr[1:0] != 0 SHALL set bus_err and proceed with the aligned address.
REQ-029 bus_err SHALL clear only on reset.
REQ-030 m_rvalid outside WAIT and m_gnt outside REQ SHALL be ignored.

Reset
REQ-031 On reset: FSM to IDLE; m_req, m_we, stall and bus_err to 0; rdata, m_addr and m_wdata to 0; wait counter to 0.
REQ-032 Reset mid-access SHALL abandon the access; m_req SHALL be 0 in the cycle after the reset edge.

Configuration
REQ-033 Macro DMEM_WBUF_EN SHALL compile in a one-entry posted write buffer.
REQ-034 With DMEM_WBUF_EN, a store in IDLE with the buffer empty SHALL be captured with stall = 0; the FSM SHALL drain it through REQ and return directly to IDLE on m_gnt.
REQ-035 With DMEM_WBUF_EN, any load or store arriving while the buffer is full or the FSM is not IDLE SHALL stall until the drain completes, preserving program order.
REQ-036 Without DMEM_WBUF_EN, stores SHALL follow REQ-019 to REQ-023.

Structure
REQ-037 Package dmem_pkg SHALL hold the state enum, MAX_WAIT default and the wait counter width.
REQ-038 Sub-module dmem_wbuf SHALL hold the write buffer (valid, addr, data) and be instantiated only under DMEM_WBUF_EN.

Verification
REQ-039 Load addr=0x100, m_gnt on first REQ cycle, m_rvalid one cycle later with 0xDEADBEEF -> stall high 3 cycles, rdata=0xDEADBEEF in DONE, one m_req pulse.
REQ-040 Store addr=0x20, wdata=0x12345678, m_gnt delayed 4 cycles -> m_addr and m_wdata stable for 5 cycles; stall low in DONE; no buffer.
REQ-041 Load with m_gnt never asserted, MAX_WAIT=8 -> m_req drops after 8 cycles, bus_err=1, rdata=0, stall released.
REQ-042 Load addr=0x103 -> m_addr=0x100, bus_err set and sticky until reset.
REQ-043 Reset asserted while in WAIT -> next cycle FSM IDLE, m_req=0, stall=0, bus_err=0; a late m_rvalid is ignored.
REQ-044 DMEM_WBUF_EN: store then load back-to-back -> store no stall, load stalls until drain m_gnt, then issues; memory sees write before read.
